// File: rtl/sim_pkg.sv
// Types and saturation helpers shared by the node integrator and the spring force calculator.
package sim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } integrator_state_t;

  // Clamp a signed value to the range of a signed field that is `bits` wide.
  function automatic int sat_signed(input int value, input int unsigned bits);
    int hi;
    int lo;
    hi = (1 <<< (bits - 1)) - 1;
    lo = -hi - 1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic int sat_pos(input int value, input int unsigned bits);
    return sat_signed(value, bits);
  endfunction

  function automatic int sat_vel(input int value, input int unsigned bits);
    return sat_signed(value, bits);
  endfunction

endpackage

// File: rtl/node_integrator_node_step.sv
// Single-node integration step: force scaling, gravity, saturation and floor clamp.
module node_step
  import sim_pkg::*;
#(
  parameter int unsigned POSITION_SIZE = 8,
  parameter int unsigned VELOCITY_SIZE = 8,
  parameter int unsigned FORCE_SIZE    = 8,
  parameter int unsigned DT_SHIFT      = 2,
  parameter int unsigned GRAVITY       = 1,
  parameter int          FLOOR_Y       = 0
) (
  input  logic signed [POSITION_SIZE-1:0] px,
  input  logic signed [POSITION_SIZE-1:0] py,
  input  logic signed [VELOCITY_SIZE-1:0] vx,
  input  logic signed [VELOCITY_SIZE-1:0] vy,
  input  logic signed [FORCE_SIZE-1:0]    fx,
  input  logic signed [FORCE_SIZE-1:0]    fy,
  output logic signed [POSITION_SIZE-1:0] px_next,
  output logic signed [POSITION_SIZE-1:0] py_next,
  output logic signed [VELOCITY_SIZE-1:0] vx_next,
  output logic signed [VELOCITY_SIZE-1:0] vy_next
);

  localparam int unsigned MAX_PV = (POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE;
  localparam int unsigned MAX_W  = (MAX_PV > FORCE_SIZE) ? MAX_PV : FORCE_SIZE;
  localparam int unsigned W      = MAX_W + 2;

  localparam logic signed [W-1:0] GRAV_W  = W'(GRAVITY);
  localparam logic signed [W-1:0] FLOOR_W = W'(FLOOR_Y);

  logic signed [W-1:0] fx_s;
  logic signed [W-1:0] fy_s;
  logic signed [W-1:0] vx_sum;
  logic signed [W-1:0] vy_sum;
  logic signed [W-1:0] px_sum;
  logic signed [W-1:0] py_sum;

  always_comb begin
    fx_s   = W'(fx) >>> DT_SHIFT;
    fy_s   = W'(fy) >>> DT_SHIFT;
    vx_sum = W'(vx) + fx_s;
    vy_sum = W'(vy) + fy_s - GRAV_W;

    vx_next = VELOCITY_SIZE'(sat_vel(int'(vx_sum), VELOCITY_SIZE));
    vy_next = VELOCITY_SIZE'(sat_vel(int'(vy_sum), VELOCITY_SIZE));

    // Position integrates the already-saturated new velocity.
    px_sum = W'(px) + W'(vx_next);
    py_sum = W'(py) + W'(vy_next);

    px_next = POSITION_SIZE'(sat_pos(int'(px_sum), POSITION_SIZE));
    py_next = POSITION_SIZE'(sat_pos(int'(py_sum), POSITION_SIZE));

    if (W'(py_next) < FLOOR_W) begin
      py_next = POSITION_SIZE'(FLOOR_Y);
      if (vy_next < 0) begin
        vy_next = '0;
      end
    end
  end

endmodule

// File: rtl/node_integrator.sv
// Integrates all nodes one per cycle after each force pulse; owns node position/velocity state.
module node_integrator
  import sim_pkg::*;
#(
  parameter int unsigned NUM_NODES     = 10,
  parameter int unsigned POSITION_SIZE = 8,
  parameter int unsigned VELOCITY_SIZE = 8,
  parameter int unsigned FORCE_SIZE    = 8,
  parameter int unsigned DT_SHIFT      = 2,
  parameter int unsigned GRAVITY       = 1,
  parameter int          FLOOR_Y       = 0
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            init_valid,
  input  logic signed [POSITION_SIZE-1:0] init_nodes      [NUM_NODES][2],
  input  logic signed [VELOCITY_SIZE-1:0] init_velocities [NUM_NODES][2],
  input  logic                            forces_valid,
  input  logic signed [FORCE_SIZE-1:0]    spring_forces   [NUM_NODES][2],
  output logic signed [POSITION_SIZE-1:0] nodes           [NUM_NODES][2],
  output logic signed [VELOCITY_SIZE-1:0] velocities      [NUM_NODES][2],
  output logic                            busy,
  output logic                            step_valid
);

  localparam int unsigned IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  integrator_state_t state;
  logic [IDX_W-1:0]  idx;
  logic signed [FORCE_SIZE-1:0] forces [NUM_NODES][2];

  logic signed [POSITION_SIZE-1:0] px_next;
  logic signed [POSITION_SIZE-1:0] py_next;
  logic signed [VELOCITY_SIZE-1:0] vx_next;
  logic signed [VELOCITY_SIZE-1:0] vy_next;

  node_step #(
    .POSITION_SIZE(POSITION_SIZE),
    .VELOCITY_SIZE(VELOCITY_SIZE),
    .FORCE_SIZE   (FORCE_SIZE),
    .DT_SHIFT     (DT_SHIFT),
    .GRAVITY      (GRAVITY),
    .FLOOR_Y      (FLOOR_Y)
  ) u_node_step (
    .px      (nodes[idx][0]),
    .py      (nodes[idx][1]),
    .vx      (velocities[idx][0]),
    .vy      (velocities[idx][1]),
    .fx      (forces[idx][0]),
    .fy      (forces[idx][1]),
    .px_next (px_next),
    .py_next (py_next),
    .vx_next (vx_next),
    .vy_next (vy_next)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      step_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_NODES; i++) begin
        for (int unsigned a = 0; a < 2; a++) begin
          nodes[i][a]      <= '0;
          velocities[i][a] <= '0;
          forces[i][a]     <= '0;
        end
      end
    end else begin
      step_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Init takes priority; a coincident force pulse is dropped, not deferred.
          if (init_valid) begin
            nodes      <= init_nodes;
            velocities <= init_velocities;
          end else if (forces_valid) begin
            forces <= spring_forces;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          nodes[idx][0]      <= px_next;
          nodes[idx][1]      <= py_next;
          velocities[idx][0] <= vx_next;
          velocities[idx][1] <= vy_next;
          if (idx == LAST_IDX) begin
            step_valid <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_node_integrator.sv
// Directed bench for node_integrator: a 1-node instance for basic timing and a 10-node instance.
module tb_node_integrator;

  localparam int N = 10;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic              init_valid = 1'b0;
  logic              forces_valid = 1'b0;
  logic signed [7:0] init_nodes      [N][2];
  logic signed [7:0] init_velocities [N][2];
  logic signed [7:0] spring_forces   [N][2];
  logic signed [7:0] nodes           [N][2];
  logic signed [7:0] velocities      [N][2];
  logic              busy;
  logic              step_valid;

  logic              one_init_valid = 1'b0;
  logic              one_forces_valid = 1'b0;
  logic signed [7:0] one_init_nodes      [1][2];
  logic signed [7:0] one_init_velocities [1][2];
  logic signed [7:0] one_spring_forces   [1][2];
  logic signed [7:0] one_nodes           [1][2];
  logic signed [7:0] one_velocities      [1][2];
  logic              one_busy;
  logic              one_step_valid;

  logic signed [7:0] exp_p [N][2];
  logic signed [7:0] exp_v [N][2];

  int passed = 0;
  int total  = 0;

  node_integrator #(.NUM_NODES(N)) u_dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .init_valid      (init_valid),
    .init_nodes      (init_nodes),
    .init_velocities (init_velocities),
    .forces_valid    (forces_valid),
    .spring_forces   (spring_forces),
    .nodes           (nodes),
    .velocities      (velocities),
    .busy            (busy),
    .step_valid      (step_valid)
  );

  node_integrator #(.NUM_NODES(1)) u_one (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .init_valid      (one_init_valid),
    .init_nodes      (one_init_nodes),
    .init_velocities (one_init_velocities),
    .forces_valid    (one_forces_valid),
    .spring_forces   (one_spring_forces),
    .nodes           (one_nodes),
    .velocities      (one_velocities),
    .busy            (one_busy),
    .step_valid      (one_step_valid)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_vec(input int n, input int px, input int py, input int vx, input int vy,
                         input int fx, input int fy, input int epx, input int epy,
                         input int evx, input int evy);
    init_nodes[n][0]      = 8'(px);
    init_nodes[n][1]      = 8'(py);
    init_velocities[n][0] = 8'(vx);
    init_velocities[n][1] = 8'(vy);
    spring_forces[n][0]   = 8'(fx);
    spring_forces[n][1]   = 8'(fy);
    exp_p[n][0]           = 8'(epx);
    exp_p[n][1]           = 8'(epy);
    exp_v[n][0]           = 8'(evx);
    exp_v[n][1]           = 8'(evy);
  endtask

  task automatic test_reset();
    for (int n = 0; n < N; n++) begin
      for (int a = 0; a < 2; a++) begin
        init_nodes[n][a] = '0; init_velocities[n][a] = '0; spring_forces[n][a] = '0;
      end
    end
    for (int a = 0; a < 2; a++) begin
      one_init_nodes[0][a] = '0; one_init_velocities[0][a] = '0; one_spring_forces[0][a] = '0;
    end
    rst_in = 1'b1;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (step_valid !== 1'b0) $display("FAIL reset_step_valid: got %b expected 0", step_valid); else passed++;
    total++; if (one_busy !== 1'b0 || one_step_valid !== 1'b0)
      $display("FAIL reset_one_flags: got busy=%b step=%b expected 0 0", one_busy, one_step_valid);
    else passed++;
    for (int n = 0; n < N; n++) begin
      total++;
      if (nodes[n][0] !== '0 || nodes[n][1] !== '0 || velocities[n][0] !== '0 || velocities[n][1] !== '0)
        $display("FAIL reset_node%0d: got p=(%0d,%0d) v=(%0d,%0d) expected all 0", n,
                 nodes[n][0], nodes[n][1], velocities[n][0], velocities[n][1]);
      else passed++;
    end
    rst_in = 1'b0;
  endtask

  task automatic test_basic_step();
    one_init_nodes[0][0] = 8'sd10; one_init_nodes[0][1] = 8'sd20;
    one_init_velocities[0][0] = 8'sd0; one_init_velocities[0][1] = 8'sd0;
    one_init_valid = 1'b1;
    tick();
    one_init_valid = 1'b0;
    total++; if (one_nodes[0][0] !== 8'sd10 || one_nodes[0][1] !== 8'sd20)
      $display("FAIL basic_init: got (%0d,%0d) expected (10,20)", one_nodes[0][0], one_nodes[0][1]);
    else passed++;
    one_spring_forces[0][0] = 8'sd8; one_spring_forces[0][1] = 8'sd4;
    one_forces_valid = 1'b1;
    tick();
    one_forces_valid = 1'b0;
    total++; if (one_step_valid !== 1'b0 || one_busy !== 1'b1)
      $display("FAIL basic_cycle1: got step=%b busy=%b expected 0 1", one_step_valid, one_busy);
    else passed++;
    tick();
    total++; if (one_step_valid !== 1'b1 || one_busy !== 1'b1)
      $display("FAIL basic_cycle2: got step=%b busy=%b expected 1 1", one_step_valid, one_busy);
    else passed++;
    total++; if (one_velocities[0][0] !== 8'sd2 || one_velocities[0][1] !== 8'sd0)
      $display("FAIL basic_vel: got (%0d,%0d) expected (2,0)", one_velocities[0][0], one_velocities[0][1]);
    else passed++;
    total++; if (one_nodes[0][0] !== 8'sd12 || one_nodes[0][1] !== 8'sd20)
      $display("FAIL basic_pos: got (%0d,%0d) expected (12,20)", one_nodes[0][0], one_nodes[0][1]);
    else passed++;
    tick();
    total++; if (one_step_valid !== 1'b0 || one_busy !== 1'b0)
      $display("FAIL basic_cycle3: got step=%b busy=%b expected 0 0", one_step_valid, one_busy);
    else passed++;
  endtask

  // Floor, saturation and negative-shift cases, one per node, run through the handshake timing.
  task automatic test_step_and_handshake();
    //          n  px   py   vx   vy   fx   fy   epx  epy  evx  evy
    set_vec(0,    5,   2,   0,  -3,   0,   0,    5,   0,   0,   0);
    set_vec(1,  120,  50, 127,   0,  40,   0,  127,  49, 127,  -1);
    set_vec(2,    0,  50,-128,   0, -40,   0, -128,  49,-128,  -1);
    set_vec(3,    0,  50,   0,   0,  -5,   0,   -2,  49,  -2,  -1);
    set_vec(4,    0,  50,   0,   0,  -1,   0,   -1,  49,  -1,  -1);
    set_vec(5, -100, 100,  10, 127,   0,  40,  -90, 127,  10, 127);
    set_vec(6,    3, -10,   0,   5,   0,   0,    3,   0,   0,   4);
    set_vec(7, -120,  10,-100,   0,-128,   0, -128,   9,-128,  -1);
    set_vec(8,    0,   0,   0,   0,   0,   0,    0,   0,   0,   0);
    set_vec(9,    7,   7,   1,   1, 127,   3,   39,   7,  32,   0);
    init_valid = 1'b1;
    tick();
    init_valid = 1'b0;
    for (int n = 0; n < N; n++) begin
      total++;
      if (nodes[n][0] !== init_nodes[n][0] || nodes[n][1] !== init_nodes[n][1] ||
          velocities[n][0] !== init_velocities[n][0] || velocities[n][1] !== init_velocities[n][1])
        $display("FAIL init_load_node%0d: got p=(%0d,%0d) v=(%0d,%0d) expected p=(%0d,%0d) v=(%0d,%0d)", n,
                 nodes[n][0], nodes[n][1], velocities[n][0], velocities[n][1],
                 init_nodes[n][0], init_nodes[n][1], init_velocities[n][0], init_velocities[n][1]);
      else passed++;
    end
    forces_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) forces_valid = 1'b0;
      if (c == 3) begin
        forces_valid = 1'b1;
        for (int n = 0; n < N; n++) begin
          spring_forces[n][0] = 8'sd64; spring_forces[n][1] = 8'sd64;
        end
      end
      if (c == 4) forces_valid = 1'b0;
      total++;
      if (busy !== ((c >= 1 && c <= 11) ? 1'b1 : 1'b0))
        $display("FAIL hs_busy_cycle%0d: got %b expected %b", c, busy, (c >= 1 && c <= 11) ? 1'b1 : 1'b0);
      else passed++;
      total++;
      if (step_valid !== ((c == 11) ? 1'b1 : 1'b0))
        $display("FAIL hs_step_valid_cycle%0d: got %b expected %b", c, step_valid, (c == 11) ? 1'b1 : 1'b0);
      else passed++;
      if (c == 11) begin
        for (int n = 0; n < N; n++) begin
          total++;
          if (nodes[n][0] !== exp_p[n][0] || nodes[n][1] !== exp_p[n][1] ||
              velocities[n][0] !== exp_v[n][0] || velocities[n][1] !== exp_v[n][1])
            $display("FAIL step_node%0d: got p=(%0d,%0d) v=(%0d,%0d) expected p=(%0d,%0d) v=(%0d,%0d)", n,
                     nodes[n][0], nodes[n][1], velocities[n][0], velocities[n][1],
                     exp_p[n][0], exp_p[n][1], exp_v[n][0], exp_v[n][1]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int n = 0; n < N; n++) begin
      init_nodes[n][0] = 8'(n); init_nodes[n][1] = 8'(2 * n + 1);
      init_velocities[n][0] = 8'(-n); init_velocities[n][1] = 8'(n);
      spring_forces[n][0] = 8'sd20; spring_forces[n][1] = 8'sd20;
    end
    init_valid = 1'b1;
    forces_valid = 1'b1;
    tick();
    init_valid = 1'b0;
    forces_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      total++;
      if (busy !== 1'b0 || step_valid !== 1'b0)
        $display("FAIL simul_no_step_cycle%0d: got busy=%b step=%b expected 0 0", c, busy, step_valid);
      else passed++;
      tick();
    end
    for (int n = 0; n < N; n++) begin
      total++;
      if (nodes[n][0] !== 8'(n) || nodes[n][1] !== 8'(2 * n + 1) ||
          velocities[n][0] !== 8'(-n) || velocities[n][1] !== 8'(n))
        $display("FAIL simul_init_node%0d: got p=(%0d,%0d) v=(%0d,%0d) expected p=(%0d,%0d) v=(%0d,%0d)", n,
                 nodes[n][0], nodes[n][1], velocities[n][0], velocities[n][1], n, 2 * n + 1, -n, n);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_update();
    forces_valid = 1'b1;
    tick();
    forces_valid = 1'b0;
    tick(); tick(); tick(); tick();
    rst_in = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || step_valid !== 1'b0)
      $display("FAIL midrst_flags: got busy=%b step=%b expected 0 0", busy, step_valid);
    else passed++;
    for (int n = 0; n < N; n++) begin
      total++;
      if (nodes[n][0] !== '0 || nodes[n][1] !== '0 || velocities[n][0] !== '0 || velocities[n][1] !== '0)
        $display("FAIL midrst_node%0d: got p=(%0d,%0d) v=(%0d,%0d) expected all 0", n,
                 nodes[n][0], nodes[n][1], velocities[n][0], velocities[n][1]);
      else passed++;
    end
    #2;
    rst_in = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      total++;
      if (busy !== 1'b0 || step_valid !== 1'b0)
        $display("FAIL midrst_idle_cycle%0d: got busy=%b step=%b expected 0 0", c, busy, step_valid);
      else passed++;
    end
  endtask

  task automatic test_after_reset();
    for (int n = 0; n < N; n++) begin
      spring_forces[n][0] = 8'sd8; spring_forces[n][1] = 8'sd8;
    end
    forces_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      forces_valid = 1'b0;
      total++;
      if (step_valid !== ((c == 11) ? 1'b1 : 1'b0))
        $display("FAIL post_step_valid_cycle%0d: got %b expected %b", c, step_valid, (c == 11) ? 1'b1 : 1'b0);
      else passed++;
      if (c == 11) begin
        for (int n = 0; n < N; n++) begin
          total++;
          if (nodes[n][0] !== 8'sd2 || nodes[n][1] !== 8'sd1 ||
              velocities[n][0] !== 8'sd2 || velocities[n][1] !== 8'sd1)
            $display("FAIL post_node%0d: got p=(%0d,%0d) v=(%0d,%0d) expected p=(2,1) v=(2,1)", n,
                     nodes[n][0], nodes[n][1], velocities[n][0], velocities[n][1]);
          else passed++;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_step();
    test_step_and_handshake();
    test_simultaneous();
    test_reset_mid_update();
    test_after_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
